// File: rtl/mdio_master.sv
// Clause-45 MDIO management master.
// Accepts one host request at a time and shifts out a 64-bit MDIO frame on
// mdc/mdio_o/mdio_t. For read opcodes the bus is released from the first
// turnaround bit, and the PHY response is shifted in on rising mdc.
module mdio_master #(
  parameter int CLK_DIV = 9
) (
  input  logic        host_clk,
  input  logic        host_reset_n,
  input  logic [1:0]  host_opcode,
  input  logic [9:0]  host_addr,
  input  logic [31:0] host_wr_data,
  input  logic        host_miim_sel,
  input  logic        host_req,
  output logic        host_miim_rdy,
  output logic [31:0] host_rd_data,
  output logic        host_rd_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam int DW = $clog2(CLK_DIV + 2);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_div;
  logic [5:0]    r_bit;
  logic          r_mdc, r_mdio_o, r_mdio_t, r_rdy;
  logic          r_rd;
  logic [62:0]   r_sr;
  logic [15:0]   r_rx;
  logic          r_ta_err;
  logic [15:0]   r_rd_data;
  logic          r_rd_err;

  logic          w_accept, w_active, w_tick, w_fall;
  logic [63:0]   w_frame;
  logic          w_unused;

  // Upper half of the write word carries nothing for MDIO.
  assign w_unused = ^host_wr_data[31:16];

  assign w_accept = host_req & host_miim_sel & r_rdy;
  assign w_active = (r_state == S_PRE) || (r_state == S_HDR) ||
                    (r_state == S_TA)  || (r_state == S_DATA);
  assign w_tick   = w_active && (r_div == DIV_MAX);
  assign w_fall   = w_tick && r_mdc;   // end of the current bit

  // Whole frame, MSB first. Read ops put 1s in the released TA/data slots.
  assign w_frame = {32'hFFFF_FFFF, 2'b00, host_opcode, host_addr,
                    (host_opcode[1] ? 2'b11 : 2'b10),
                    (host_opcode[1] ? 16'hFFFF : host_wr_data[15:0])};

  // State register.
  always_ff @(posedge host_clk or negedge host_reset_n) begin
    if (!host_reset_n) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  // Next-state: frame segment boundaries come from the bit counter.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)                    w_next = S_PRE;
      S_PRE:  if (w_fall && r_bit == 6'd31)    w_next = S_HDR;
      S_HDR:  if (w_fall && r_bit == 6'd45)    w_next = S_TA;
      S_TA:   if (w_fall && r_bit == 6'd47)    w_next = S_DATA;
      S_DATA: if (w_fall && r_bit == 6'd63)    w_next = S_DONE;
      S_DONE:                                  w_next = S_IDLE;
      default:                                 w_next = S_IDLE;
    endcase
  end

  // Divider, bit counter, serialiser, PHY sampling and host result registers.
  always_ff @(posedge host_clk or negedge host_reset_n) begin
    if (!host_reset_n) begin
      r_div     <= '0;
      r_bit     <= '0;
      r_mdc     <= 1'b0;
      r_mdio_o  <= 1'b1;
      r_mdio_t  <= 1'b1;
      r_rdy     <= 1'b1;
      r_rd      <= 1'b0;
      r_sr      <= '1;
      r_rx      <= '0;
      r_ta_err  <= 1'b0;
      r_rd_data <= '0;
      r_rd_err  <= 1'b0;
    end else if (w_accept) begin
      // First preamble bit goes out on the accept edge with mdc low.
      r_div    <= '0;
      r_bit    <= '0;
      r_mdc    <= 1'b0;
      r_mdio_o <= w_frame[63];
      r_mdio_t <= 1'b0;
      r_sr     <= w_frame[62:0];
      r_rd     <= host_opcode[1];
      r_rdy    <= 1'b0;
      r_rx     <= '0;
      r_ta_err <= 1'b0;
    end else if (w_active) begin
      if (r_div == DIV_MAX) begin
        r_div <= '0;
        if (!r_mdc) begin
          // Rising mdc: PHY data is sampled here.
          r_mdc <= 1'b1;
          if (r_rd && r_bit == 6'd47) r_ta_err <= mdio_i;
          if (r_rd && r_bit >= 6'd48) r_rx     <= {r_rx[14:0], mdio_i};
        end else begin
          // Falling mdc: advance to the next bit, or park the bus after the last.
          r_mdc <= 1'b0;
          if (r_bit == 6'd63) begin
            r_mdio_o <= 1'b1;
            r_mdio_t <= 1'b1;
          end else begin
            r_bit    <= r_bit + 6'd1;
            r_mdio_o <= r_sr[62];
            r_sr     <= {r_sr[61:0], 1'b1};
            r_mdio_t <= r_rd && (r_bit >= 6'd45);
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end else if (r_state == S_DONE) begin
      r_rdy <= 1'b1;
      r_bit <= '0;
      if (r_rd) begin
        r_rd_data <= r_rx;
        r_rd_err  <= r_ta_err;
      end
    end
  end

  assign host_miim_rdy = r_rdy;
  assign host_rd_data  = {16'h0000, r_rd_data};
  assign host_rd_err   = r_rd_err;
  assign mdc           = r_mdc;
  assign mdio_o        = r_mdio_o;
  assign mdio_t        = r_mdio_t;

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: stimulus pushes the expected frame and
// host result; a negedge monitor captures each frame bit on rising mdc and
// compares when host_miim_rdy returns. A second instance checks CLK_DIV=9.
module tb_mdio_master;

  logic        host_clk = 1'b0;
  logic        host_reset_n = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        sel = 1'b0, req = 1'b0;
  logic        rdy, rd_err, mdc, mdio_o, mdio_t, mdio_i;
  logic [31:0] rd_data;

  logic        req9 = 1'b0;
  logic        rdy9, rd_err9, mdc9, mdio_o9, mdio_t9;
  logic [31:0] rd_data9;

  // PHY model state
  logic        phy_absent = 1'b0, phy_ta2 = 1'b0;
  logic [15:0] phy_data = '0;
  int          mon_bits = 0;
  logic [3:0]  w_idx;

  int n_checks = 0, n_fail = 0;

  typedef struct {
    logic [63:0] fo;
    logic [63:0] ft;
    int          lat;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 host_clk = ~host_clk;

  mdio_master #(.CLK_DIV(1)) dut (
    .host_clk(host_clk), .host_reset_n(host_reset_n), .host_opcode(op),
    .host_addr(addr), .host_wr_data(wdata), .host_miim_sel(sel),
    .host_req(req), .host_miim_rdy(rdy), .host_rd_data(rd_data),
    .host_rd_err(rd_err), .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t),
    .mdio_i(mdio_i));

  mdio_master #(.CLK_DIV(9)) dut9 (
    .host_clk(host_clk), .host_reset_n(host_reset_n), .host_opcode(op),
    .host_addr(addr), .host_wr_data(wdata), .host_miim_sel(sel),
    .host_req(req9), .host_miim_rdy(rdy9), .host_rd_data(rd_data9),
    .host_rd_err(rd_err9), .mdc(mdc9), .mdio_o(mdio_o9), .mdio_t(mdio_t9),
    .mdio_i(1'b1));

  // PHY answers by frame bit index: TA2 at bit 47, data at bits 48..63.
  assign w_idx  = 4'(63 - mon_bits);
  assign mdio_i = phy_absent ? 1'b1 :
                  (mon_bits == 47) ? phy_ta2 :
                  (mon_bits >= 48 && mon_bits <= 63) ? phy_data[w_idx] : 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: arm when rdy drops, capture on mdc rise, compare when rdy returns.
  initial begin
    logic        armed, prev_rdy, prev_mdc;
    int          cyc;
    logic [63:0] obs_o, obs_t;
    exp_t        e;
    armed = 1'b0; prev_rdy = 1'b1; prev_mdc = 1'b0; cyc = 0;
    obs_o = '0; obs_t = '0;
    forever begin
      @(negedge host_clk);
      if (!host_reset_n) begin
        armed = 1'b0; prev_rdy = 1'b1; prev_mdc = 1'b0; mon_bits = 0;
      end else begin
        if (armed) cyc++;
        if (armed && mdc && !prev_mdc) begin
          obs_o = {obs_o[62:0], mdio_o};
          obs_t = {obs_t[62:0], mdio_t};
          mon_bits++;
        end
        if (armed && rdy) begin
          armed = 1'b0;
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_frame: no expected entry, lat %0d", cyc - 1);
          end else begin
            e = sb.pop_front();
            check("frame_mdio_o", obs_o & ~e.ft, e.fo & ~e.ft);
            check("frame_mdio_t", obs_t, e.ft);
            check("rdy_latency", 64'(cyc - 1), 64'(e.lat));
            check("rd_data", 64'(rd_data), 64'(e.rd));
            check("rd_err", 64'(rd_err), 64'(e.err));
          end
        end
        if (prev_rdy && !rdy) begin
          armed = 1'b1; cyc = 1; mon_bits = 0; obs_o = '0; obs_t = '0;
        end
        prev_rdy = rdy;
        prev_mdc = mdc;
      end
    end
  end

  task automatic start(input logic [1:0] o, input logic [9:0] a, input logic [15:0] d,
                       input logic [63:0] fo, input logic is_rd, input logic [31:0] rd,
                       input logic err, input logic push);
    exp_t e;
    e.fo = fo; e.ft = is_rd ? 64'h3FFFF : 64'h0; e.lat = 257; e.rd = rd; e.err = err;
    if (push) sb.push_back(e);
    @(posedge host_clk); #1;
    op = o; addr = a; wdata = {16'hDEAD, d}; sel = 1'b1; req = 1'b1;
    @(posedge host_clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge host_clk);
      if (rdy) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL rdy_timeout: rdy %b expected 1", rdy);
    end
    @(negedge host_clk);
  endtask

  initial begin
    bit ok;
    int cyc, hi, rises;
    logic pm;

    // Reset values, while held and after release
    repeat (2) @(posedge host_clk);
    #1;
    check("rst_rdy", 64'(rdy), 64'h1);
    check("rst_rd_data", 64'(rd_data), 64'h0);
    check("rst_rd_err", 64'(rd_err), 64'h0);
    check("rst_mdc", 64'(mdc), 64'h0);
    check("rst_mdio_o", 64'(mdio_o), 64'h1);
    check("rst_mdio_t", 64'(mdio_t), 64'h1);
    host_reset_n = 1'b1;

    // Write, address
    start(2'b01, 10'h021, 16'hA5C3, 64'hFFFFFFFF_1086A5C3, 1'b0, 32'h0, 1'b0, 1'b1);
    wait_done();
    start(2'b00, 10'h021, 16'h0800, 64'hFFFFFFFF_00860800, 1'b0, 32'h0, 1'b0, 1'b1);
    wait_done();

    // Request with sel=0 while idle: nothing happens
    @(posedge host_clk); #1;
    sel = 1'b0; req = 1'b1;
    @(posedge host_clk); #1;
    req = 1'b0;
    repeat (20) @(negedge host_clk);
    check("sel0_rdy", 64'(rdy), 64'h1);
    check("sel0_mdc", 64'(mdc), 64'h0);
    check("sel0_mdio_t", 64'(mdio_t), 64'h1);

    // Read with a PHY present, plus a stray request mid-frame
    phy_absent = 1'b0; phy_ta2 = 1'b0; phy_data = 16'h1234;
    start(2'b11, 10'h3E5, 16'h0000, 64'hFFFFFFFF_3F96FFFF, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
    repeat (100) @(posedge host_clk);
    #1; sel = 1'b1; req = 1'b1;
    @(posedge host_clk); #1;
    req = 1'b0;
    wait_done();

    // Post-read-increment with PHY absent, then a write that must not disturb the result
    phy_absent = 1'b1;
    start(2'b10, 10'h3E5, 16'h0000, 64'hFFFFFFFF_2F96FFFF, 1'b1, 32'h0000_FFFF, 1'b1, 1'b1);
    wait_done();
    start(2'b01, 10'h3E5, 16'h0F0F, 64'hFFFFFFFF_1F960F0F, 1'b0, 32'h0000_FFFF, 1'b1, 1'b1);
    wait_done();

    // Good read clears the error flag
    phy_absent = 1'b0; phy_ta2 = 1'b0; phy_data = 16'hBEEF;
    start(2'b11, 10'h021, 16'h0000, 64'hFFFFFFFF_3086FFFF, 1'b1, 32'h0000_BEEF, 1'b0, 1'b1);
    wait_done();

    // Reset at bit 40 of a read: abort, no completion
    phy_data = 16'h7777;
    start(2'b11, 10'h021, 16'h0000, 64'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge host_clk);
      if (mon_bits == 40) ok = 1'b1;
    end
    check("reach_bit40", 64'(ok), 64'h1);
    @(posedge host_clk); #2;
    host_reset_n = 1'b0;
    #1;
    check("abort_rdy", 64'(rdy), 64'h1);
    check("abort_mdc", 64'(mdc), 64'h0);
    check("abort_mdio_o", 64'(mdio_o), 64'h1);
    check("abort_mdio_t", 64'(mdio_t), 64'h1);
    check("abort_rd_data", 64'(rd_data), 64'h0);
    check("abort_rd_err", 64'(rd_err), 64'h0);
    repeat (3) @(posedge host_clk);
    #1; host_reset_n = 1'b1;
    repeat (300) @(negedge host_clk);
    check("post_abort_rd_data", 64'(rd_data), 64'h0);
    check("post_abort_rdy", 64'(rdy), 64'h1);
    start(2'b01, 10'h021, 16'h5555, 64'hFFFFFFFF_10865555, 1'b0, 32'h0, 1'b0, 1'b1);
    wait_done();

    // CLK_DIV=9 instance: MDC period 20 with 50% duty, rdy after 1281 cycles
    @(posedge host_clk); #1;
    op = 2'b01; addr = 10'h021; wdata = 32'h0000_A5C3; sel = 1'b1; req9 = 1'b1;
    @(posedge host_clk); #1;
    req9 = 1'b0;
    cyc = 0; hi = 0; rises = 0; pm = 1'b0; ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge host_clk);
      cyc++;
      if (cyc == 1) check("div9_rdy_drop", 64'(rdy9), 64'h0);
      if (rdy9) ok = 1'b1;
      else begin
        if (mdc9) hi++;
        if (mdc9 && !pm) rises++;
        pm = mdc9;
      end
    end
    check("div9_latency", 64'(cyc - 1), 64'd1281);
    check("div9_mdc_rises", 64'(rises), 64'd64);
    check("div9_mdc_high", 64'(hi), 64'd640);

    repeat (2) @(negedge host_clk);
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 9: MDC half-period = CLK_DIV+1 host_clk cycles (2.5 MHz MDC at 50 MHz).
REQ-002 SHALL have port host_clk, input, 1: clock, 50 MHz domain.
REQ-003 SHALL have port host_reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port host_opcode, input, 2: clause-45 OP field (00 address, 01 write, 11 read, 10 post-read-increment).
REQ-005 SHALL have port host_addr, input, 10: [9:5] PRTAD, [4:0] DEVAD.
REQ-006 SHALL have port host_wr_data, input, 32: [15:0] is the address or write payload; [31:16] is ignored.
REQ-007 SHALL have port host_miim_sel, input, 1: 1 = MDIO access; 0 = request not for this block.
REQ-008 SHALL have port host_req, input, 1: single-cycle request strobe.
REQ-009 SHALL have port host_miim_rdy, output, 1: idle and able to accept a request.
REQ-010 SHALL have port host_rd_data, output, 32: read result.
REQ-011 SHALL have port host_rd_err, output, 1: turnaround error on the last read.
REQ-012 SHALL have port mdc, output, 1: MDIO clock.
REQ-013 SHALL have port mdio_o, output, 1: serial data out.
REQ-014 SHALL have port mdio_t, output, 1: tristate control; 1 = released.
REQ-015 SHALL have port mdio_i, input, 1: serial data in, already synchronised by the pad wrapper.

Function
REQ-016 SHALL accept a request on the cycle where host_req=1, host_miim_sel=1 and host_miim_rdy=1, capturing opcode, address and host_wr_data[15:0] into internal registers.
REQ-017 SHALL ignore host_req while host_miim_rdy=0, or while host_miim_sel=0: no frame, no change to any state.
REQ-018 SHALL deassert host_miim_rdy on the cycle after acceptance.
REQ-019 SHALL reassert host_miim_rdy exactly 1+128*(CLK_DIV+1) cycles after the acceptance edge.
REQ-020 SHALL implement FSM states IDLE, PRE, HDR, TA, DATA, DONE.
- IDLE -> PRE on acceptance.
- PRE: 32 bits; after 32 -> HDR.
- HDR: 14 bits (ST, OP, PRTAD, DEVAD); after 14 -> TA.
- TA: 2 bits -> DATA.
- DATA: 16 bits -> DONE.
- DONE: 1 cycle -> IDLE.
REQ-021 SHALL send the 64-bit frame MSB-first as: 32x '1', ST=00, OP, PRTAD, DEVAD, TA, 16-bit data.
REQ-022 SHALL run each bit as CLK_DIV+1 cycles with mdc=0 followed by CLK_DIV+1 cycles with mdc=1; mdio_o/mdio_t update only on the cycle mdc goes 0.
REQ-023 SHALL keep mdc=0, mdio_t=1 and mdio_o=1 in IDLE and DONE.
REQ-024 SHALL, for OP 00 or 01, drive TA=1,0 and drive the 16 data bits with mdio_t=0 throughout the frame.
REQ-025 SHALL, for OP 11 or 10, set mdio_t=1 from the first TA bit through the end of DATA.
REQ-026 SHALL, on read ops, sample mdio_i on the host_clk cycle where mdc rises, for each DATA bit, shifting it in MSB-first.
REQ-027 SHALL, on read ops, also sample the second TA bit; if it is 1, set host_rd_err=1 for that transaction.
REQ-028 SHALL, in DONE for read ops, load host_rd_data = {16'h0000, shifted data} and update host_rd_err.
REQ-029 SHALL, for address and write ops, hold host_rd_data and host_rd_err unchanged.
REQ-030 SHALL hold host_rd_data stable until the next read completes.
REQ-031 SHALL derive bit and divider counters from CLK_DIV; the divider counter wraps from CLK_DIV to 0, and the bit counter does not wrap beyond 63.

Reset
REQ-032 SHALL, with host_reset_n=0, asynchronously force: FSM=IDLE, host_miim_rdy=1, host_rd_data=0, host_rd_err=0, mdc=0, mdio_o=1, mdio_t=1, all counters 0.
REQ-033 SHALL, on reset asserted mid-frame, abort the frame immediately with no completion and no update of host_rd_data.
REQ-034 SHALL, after reset release, accept a request no earlier than the first rising edge of host_clk.

Verification (CLK_DIV=1 unless stated)
REQ-035 Write: opcode=01, addr=10'h021 (PRTAD 1, DEVAD 1), wr_data=16'hA5C3 -> mdio_o shows 32x1, 00 01 00001 00001 10 A5C3; mdio_t=0 throughout; rdy returns 257 cycles after accept.
REQ-036 Read: opcode=11, PHY model drives TA2=0 and data 16'h1234 -> mdio_t=1 from TA; host_rd_data=32'h00001234; host_rd_err=0.
REQ-037 Read with PHY absent (mdio_i pulled to 1) -> host_rd_data=32'h0000FFFF; host_rd_err=1; a following write leaves both unchanged.
REQ-038 host_req pulsed mid-frame, and host_req with host_miim_sel=0 while idle -> no extra frame; timing of the active frame unaffected.
REQ-039 host_reset_n low at bit 40 of a read -> all outputs at reset values within the reset cycle; host_rd_data stays 0; the next request completes normally.
REQ-040 CLK_DIV=9 -> MDC period 20 cycles, 50% duty; rdy returns 1281 cycles after accept.
